// File: rtl/hwpe_ctrl_offload_arbiter.sv
// Round-robin arbiter for the HWPE cfg slave port that serialises the acquire/program/commit
// offload protocol, so only the core holding the context lock reaches the slave until it commits.
module hwpe_ctrl_offload_arbiter #(
    parameter int unsigned N_CORES      = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [7:0]  ACQUIRE_OFFS = 8'h04,
    parameter logic [7:0]  TRIGGER_OFFS = 8'h00,
    parameter int unsigned TIMEOUT      = 0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [N_CORES-1:0]                      core_req_i,
    output logic [N_CORES-1:0]                      core_gnt_o,
    input  logic [N_CORES-1:0]                      core_wen_i,
    input  logic [N_CORES-1:0][ADDR_WIDTH-1:0]      core_add_i,
    input  logic [N_CORES-1:0][DATA_WIDTH-1:0]      core_data_i,
    input  logic [N_CORES-1:0][DATA_WIDTH/8-1:0]    core_be_i,
    output logic [N_CORES-1:0][DATA_WIDTH-1:0]      core_r_data_o,
    output logic [N_CORES-1:0]                      core_r_valid_o,
    output logic                                    hwpe_req_o,
    output logic                                    hwpe_wen_o,
    output logic [ADDR_WIDTH-1:0]                   hwpe_add_o,
    output logic [DATA_WIDTH-1:0]                   hwpe_data_o,
    output logic [DATA_WIDTH/8-1:0]                 hwpe_be_o,
    output logic [N_CORES-1:0]                      hwpe_id_o,
    input  logic                                    hwpe_gnt_i,
    input  logic [DATA_WIDTH-1:0]                   hwpe_r_data_i,
    input  logic                                    hwpe_r_valid_i,
    output logic                                    lock_valid_o,
    output logic [$clog2(N_CORES)-1:0]              lock_owner_o,
    output logic                                    timeout_evt_o
);

    localparam int unsigned LogCores = $clog2(N_CORES);
    localparam int unsigned CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef logic [LogCores-1:0] idx_t;

    typedef enum logic [1:0] {
        StUnlocked,
        StAcqWait,
        StLocked
    } state_e;

    state_e          state_q, state_d;
    idx_t            rr_ptr_q, rr_ptr_d;
    idx_t            owner_q, owner_d;
    idx_t            cand_q, cand_d;
    idx_t            resp_owner_q, resp_owner_d;
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_evt_q, timeout_evt_d;
    logic            rst_dly_q;

    idx_t rr_win;
    logic rr_found;
    idx_t fwd_idx;
    logic fwd_valid;
    logic handshake;
    logic is_acquire;
    logic is_commit;

    function automatic idx_t inc_idx(input idx_t i);
        if (i == idx_t'(N_CORES - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // First requester at or above rr_ptr_q, wrapping around.
    always_comb begin
        int unsigned idx;
        rr_win   = rr_ptr_q;
        rr_found = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_CORES;
            if (!rr_found && core_req_i[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx_t'(idx);
            end
        end
    end

    always_comb begin
        fwd_valid = 1'b0;
        fwd_idx   = rr_win;
        case (state_q)
            StUnlocked: begin
                fwd_valid = rr_found;
                fwd_idx   = rr_win;
            end
            StLocked: begin
                fwd_valid = core_req_i[owner_q];
                fwd_idx   = owner_q;
            end
            default: begin
                fwd_valid = 1'b0;
            end
        endcase
    end

    assign handshake  = fwd_valid & hwpe_gnt_i;
    assign is_acquire = core_wen_i[fwd_idx] & (core_add_i[fwd_idx][7:0] == ACQUIRE_OFFS);
    assign is_commit  = ~core_wen_i[fwd_idx] & (core_add_i[fwd_idx][7:0] == TRIGGER_OFFS);

    // Non-forwarded fields are held at zero so an idle port presents all-zero outputs.
    always_comb begin
        hwpe_req_o  = fwd_valid;
        hwpe_wen_o  = 1'b0;
        hwpe_add_o  = '0;
        hwpe_data_o = '0;
        hwpe_be_o   = '0;
        hwpe_id_o   = '0;
        core_gnt_o  = '0;
        if (fwd_valid) begin
            hwpe_wen_o           = core_wen_i[fwd_idx];
            hwpe_add_o           = core_add_i[fwd_idx];
            hwpe_data_o          = core_data_i[fwd_idx];
            hwpe_be_o            = core_be_i[fwd_idx];
            hwpe_id_o[fwd_idx]   = 1'b1;
            core_gnt_o[fwd_idx]  = hwpe_gnt_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cand_d        = cand_q;
        resp_owner_d  = resp_owner_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_evt_d = 1'b0;
        if (handshake) begin
            resp_owner_d = fwd_idx;
        end
        unique case (state_q)
            StUnlocked: begin
                if (handshake) begin
                    rr_ptr_d = inc_idx(fwd_idx);
                    if (is_acquire) begin
                        state_d = StAcqWait;
                        cand_d  = fwd_idx;
                    end
                end
            end
            StAcqWait: begin
                // A missing response is treated like a refused acquire.
                state_d = StUnlocked;
                if (hwpe_r_valid_i && !hwpe_r_data_i[DATA_WIDTH-1]) begin
                    state_d  = StLocked;
                    owner_d  = cand_q;
                    wd_cnt_d = '0;
                end
            end
            StLocked: begin
                if (handshake) begin
                    wd_cnt_d = '0;
                    if (is_commit) begin
                        state_d  = StUnlocked;
                        rr_ptr_d = inc_idx(owner_q);
                    end
                end else if (TIMEOUT > 0) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (wd_cnt_d == CntW'(TIMEOUT)) begin
                        state_d       = StUnlocked;
                        rr_ptr_d      = inc_idx(owner_q);
                        timeout_evt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StUnlocked;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StUnlocked;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            cand_q        <= '0;
            resp_owner_q  <= '0;
            wd_cnt_q      <= '0;
            timeout_evt_q <= 1'b0;
            rst_dly_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            cand_q        <= cand_d;
            resp_owner_q  <= resp_owner_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_evt_q <= timeout_evt_d;
            rst_dly_q     <= 1'b0;
        end
    end

    // Responses still in flight across a reset belong to a discarded transaction.
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            core_r_data_o[i]  = hwpe_r_data_i;
            core_r_valid_o[i] = hwpe_r_valid_i & ~rst_i & ~rst_dly_q &
                                (resp_owner_q == idx_t'(i));
        end
    end

    assign lock_valid_o  = (state_q == StLocked);
    assign lock_owner_o  = owner_q;
    assign timeout_evt_o = timeout_evt_q;

endmodule

// File: tb/tb_hwpe_ctrl_offload_arbiter.sv
// Bench for hwpe_ctrl_offload_arbiter: a cycle model of the offload protocol checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hwpe_ctrl_offload_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i;
    logic [3:0]         core_req, core_wen;
    logic [3:0][31:0]   core_add, core_data;
    logic [3:0][3:0]    core_be;
    logic [3:0]         core_gnt_o, core_r_valid_o;
    logic [3:0][31:0]   core_r_data_o;
    logic               hwpe_req_o, hwpe_wen_o, hwpe_gnt_i, hwpe_r_valid_i;
    logic [31:0]        hwpe_add_o, hwpe_data_o, hwpe_r_data_i;
    logic [3:0]         hwpe_be_o, hwpe_id_o;
    logic               lock_valid_o, timeout_evt_o;
    logic [1:0]         lock_owner_o;

    hwpe_ctrl_offload_arbiter #(
        .N_CORES(N), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ACQUIRE_OFFS(8'h04), .TRIGGER_OFFS(8'h00), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req), .core_gnt_o(core_gnt_o), .core_wen_i(core_wen),
        .core_add_i(core_add), .core_data_i(core_data), .core_be_i(core_be),
        .core_r_data_o(core_r_data_o), .core_r_valid_o(core_r_valid_o),
        .hwpe_req_o(hwpe_req_o), .hwpe_wen_o(hwpe_wen_o), .hwpe_add_o(hwpe_add_o),
        .hwpe_data_o(hwpe_data_o), .hwpe_be_o(hwpe_be_o), .hwpe_id_o(hwpe_id_o),
        .hwpe_gnt_i(hwpe_gnt_i), .hwpe_r_data_i(hwpe_r_data_i), .hwpe_r_valid_i(hwpe_r_valid_i),
        .lock_valid_o(lock_valid_o), .lock_owner_o(lock_owner_o), .timeout_evt_o(timeout_evt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave behaviour: respond one cycle after every handshake.
    logic [31:0] acq_resp;
    logic        rv_next;
    logic [31:0] rd_next;

    // Protocol model: mode 0 free, 1 waiting for acquire answer, 2 locked.
    int m_valid = 0;
    int m_mode, m_rr, m_owner, m_cand, m_resp, m_cnt, m_evt, m_rst_prev;
    int c;
    logic        hs;
    logic [3:0]  e_gnt, e_id, e_rv;

    always @(negedge clk) begin
        c = -1;
        if (m_mode == 2) begin
            if (core_req[m_owner]) c = m_owner;
        end else if (m_mode == 0) begin
            for (int k = 0; k < N; k++) begin
                if (c < 0 && core_req[(m_rr + k) % N]) c = (m_rr + k) % N;
            end
        end
        hs    = (c >= 0) && (hwpe_gnt_i === 1'b1);
        e_gnt = '0;
        e_id  = '0;
        e_rv  = '0;
        if (c >= 0) begin
            e_id[c] = 1'b1;
            if (hwpe_gnt_i) e_gnt[c] = 1'b1;
        end
        if (hwpe_r_valid_i && !rst_i && m_rst_prev == 0) e_rv[m_resp] = 1'b1;

        if (m_valid != 0) begin
            chk("m_hwpe_req", hwpe_req_o, c >= 0);
            chk("m_hwpe_wen", hwpe_wen_o, (c >= 0) ? core_wen[c] : 1'b0);
            chk("m_hwpe_add", hwpe_add_o, (c >= 0) ? core_add[c] : 32'h0);
            chk("m_hwpe_data", hwpe_data_o, (c >= 0) ? core_data[c] : 32'h0);
            chk("m_hwpe_be", hwpe_be_o, (c >= 0) ? core_be[c] : 4'h0);
            chk("m_hwpe_id", hwpe_id_o, e_id);
            chk("m_core_gnt", core_gnt_o, e_gnt);
            chk("m_core_r_valid", core_r_valid_o, e_rv);
            for (int i = 0; i < N; i++) chk("m_core_r_data", core_r_data_o[i], hwpe_r_data_i);
            chk("m_lock_valid", lock_valid_o, m_mode == 2);
            chk("m_lock_owner", lock_owner_o, m_owner);
            chk("m_timeout_evt", timeout_evt_o, m_evt);
        end

        rv_next = (hwpe_req_o === 1'b1) && (hwpe_gnt_i === 1'b1);
        rd_next = (hwpe_wen_o === 1'b1 && hwpe_add_o[7:0] == 8'h04) ? acq_resp
                                                                    : (hwpe_add_o ^ 32'h5A5A_0000);

        if (rst_i) begin
            m_mode = 0; m_rr = 0; m_owner = 0; m_cand = 0; m_resp = 0; m_cnt = 0; m_evt = 0;
            m_rst_prev = 1;
            m_valid    = 1;
        end else if (m_valid != 0) begin
            m_evt      = 0;
            m_rst_prev = 0;
            case (m_mode)
                0: if (hs) begin
                    m_rr   = (c + 1) % N;
                    m_resp = c;
                    if (core_wen[c] && core_add[c][7:0] == 8'h04) begin
                        m_mode = 1;
                        m_cand = c;
                    end
                end
                1: begin
                    if (hwpe_r_valid_i && !hwpe_r_data_i[31]) begin
                        m_mode  = 2;
                        m_owner = m_cand;
                        m_cnt   = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
                default: begin
                    if (hs) begin
                        m_resp = c;
                        m_cnt  = 0;
                        if (!core_wen[c] && core_add[c][7:0] == 8'h00) begin
                            m_mode = 0;
                            m_rr   = (m_owner + 1) % N;
                        end
                    end else begin
                        m_cnt++;
                        if (m_cnt == TMO) begin
                            m_mode = 0;
                            m_rr   = (m_owner + 1) % N;
                            m_evt  = 1;
                        end
                    end
                end
            endcase
        end
    end

    initial begin
        hwpe_r_valid_i = 1'b0;
        hwpe_r_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            hwpe_r_valid_i = rv_next;
            hwpe_r_data_i  = rd_next;
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wen, input logic [31:0] add);
        core_req[i]  = 1'b1;
        core_wen[i]  = wen;
        core_add[i]  = add;
        core_data[i] = 32'hD000_0000 | add | (32'(i) << 16);
        core_be[i]   = wen ? 4'hF : 4'h3;
    endtask

    int rr_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_i      = 1'b1;
        core_req   = '0;
        core_wen   = '0;
        core_add   = '0;
        core_data  = '0;
        core_be    = '0;
        hwpe_gnt_i = 1'b0;
        acq_resp   = 32'h0;
        rv_next    = 1'b0;
        rd_next    = '0;
        repeat (2) edge1();

        // Round-robin among four continuous readers.
        rst_i = 1'b0;
        hwpe_gnt_i = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h10 + 32'(4 * i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_gnt", core_gnt_o, 1 << rr_order[k]);
            chk("rr_rvalid", core_r_valid_o, (k == 0) ? 0 : (1 << rr_order[k-1]));
        end

        // Successful acquire by core 2, core 1 stalls, commit.
        edge1();
        core_req = '0;
        set_req(2, 1'b1, 32'h04);
        @(negedge clk); chk("acq2_gnt", core_gnt_o, 4'b0100);
        edge1(); core_req[2] = 1'b0; set_req(1, 1'b1, 32'h20);
        @(negedge clk);
        chk("acqwait_req", hwpe_req_o, 1'b0);
        chk("acqwait_gnt", core_gnt_o, 4'b0000);
        chk("acqwait_rvalid", core_r_valid_o, 4'b0100);
        @(negedge clk);
        chk("lock2_valid", lock_valid_o, 1'b1);
        chk("lock2_owner", lock_owner_o, 2'd2);
        chk("lock2_stall", core_gnt_o, 4'b0000);
        edge1(); set_req(2, 1'b0, 32'h00);
        @(negedge clk); chk("commit2_gnt", core_gnt_o, 4'b0100);
        edge1(); core_req[2] = 1'b0; set_req(3, 1'b1, 32'h30);
        @(negedge clk);
        chk("unlock2_valid", lock_valid_o, 1'b0);
        chk("after_commit_gnt3", core_gnt_o, 4'b1000);
        edge1(); core_req[3] = 1'b0;
        @(negedge clk); chk("lone_core1_gnt", core_gnt_o, 4'b0010);

        // Refused acquire by core 0.
        edge1(); core_req[1] = 1'b0; acq_resp = 32'hFFFF_FFFF; set_req(0, 1'b1, 32'h04);
        @(negedge clk); chk("fail_acq_gnt", core_gnt_o, 4'b0001);
        edge1(); core_req[0] = 1'b0;
        @(negedge clk);
        chk("fail_acqwait_req", hwpe_req_o, 1'b0);
        chk("fail_acqwait_lock", lock_valid_o, 1'b0);
        @(negedge clk); chk("fail_after_lock", lock_valid_o, 1'b0);

        // Watchdog expiry with idle owner.
        edge1(); acq_resp = 32'h5; set_req(0, 1'b1, 32'h04);
        @(negedge clk); chk("wd_acq_gnt", core_gnt_o, 4'b0001);
        edge1(); core_req[0] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("wd_locked", lock_valid_o, 1'b1);
            chk("wd_no_evt", timeout_evt_o, 1'b0);
        end
        @(negedge clk);
        chk("wd_evt", timeout_evt_o, 1'b1);
        chk("wd_unlocked", lock_valid_o, 1'b0);
        @(negedge clk); chk("wd_evt_once", timeout_evt_o, 1'b0);

        // Commit in the last watchdog cycle wins over the timeout.
        edge1(); set_req(0, 1'b1, 32'h04);
        @(negedge clk); chk("wdc_acq_gnt", core_gnt_o, 4'b0001);
        edge1(); core_req[0] = 1'b0;
        @(negedge clk);
        repeat (TMO - 1) begin
            @(negedge clk);
            chk("wdc_locked", lock_valid_o, 1'b1);
        end
        edge1(); set_req(0, 1'b0, 32'h00);
        @(negedge clk);
        chk("wdc_commit_gnt", core_gnt_o, 4'b0001);
        chk("wdc_still_locked", lock_valid_o, 1'b1);
        edge1(); core_req[0] = 1'b0;
        @(negedge clk);
        chk("wdc_unlocked", lock_valid_o, 1'b0);
        chk("wdc_no_evt", timeout_evt_o, 1'b0);
        @(negedge clk); chk("wdc_no_evt2", timeout_evt_o, 1'b0);

        // Stalled slave while core 3 holds the lock.
        edge1(); acq_resp = 32'h1; set_req(3, 1'b1, 32'h04);
        @(negedge clk); chk("st_acq_gnt", core_gnt_o, 4'b1000);
        edge1(); core_req[3] = 1'b0;
        @(negedge clk);
        edge1(); set_req(3, 1'b1, 32'h40); set_req(0, 1'b1, 32'h44); hwpe_gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("st_no_gnt", core_gnt_o, 4'b0000);
            chk("st_id", hwpe_id_o, 4'b1000);
            chk("st_owner", lock_owner_o, 2'd3);
        end
        edge1(); hwpe_gnt_i = 1'b1;
        @(negedge clk); chk("st_release_gnt", core_gnt_o, 4'b1000);
        edge1(); set_req(3, 1'b0, 32'h00);
        @(negedge clk);
        chk("st_commit_gnt", core_gnt_o, 4'b1000);
        chk("st_rvalid", core_r_valid_o, 4'b1000);
        edge1(); core_req[3] = 1'b0;
        @(negedge clk);
        chk("st_unlocked", lock_valid_o, 1'b0);
        chk("st_core0_gnt", core_gnt_o, 4'b0001);

        // Reset while core 1 holds the lock with a read response due.
        edge1(); core_req[0] = 1'b0; acq_resp = 32'h2; set_req(1, 1'b1, 32'h04);
        @(negedge clk); chk("rs_acq_gnt", core_gnt_o, 4'b0010);
        edge1(); core_req[1] = 1'b0;
        @(negedge clk);
        edge1(); set_req(1, 1'b1, 32'h50);
        @(negedge clk);
        chk("rs_lock_owner", lock_owner_o, 2'd1);
        chk("rs_read_gnt", core_gnt_o, 4'b0010);
        edge1(); rst_i = 1'b1; core_req[1] = 1'b0;
        @(negedge clk);
        chk("rs_rvalid_in_rst", core_r_valid_o, 4'b0000);
        edge1(); rst_i = 1'b0;
        @(negedge clk);
        chk("rs_lock_valid", lock_valid_o, 1'b0);
        chk("rs_lock_owner0", lock_owner_o, 2'd0);
        chk("rs_evt", timeout_evt_o, 1'b0);
        chk("rs_rvalid", core_r_valid_o, 4'b0000);
        chk("rs_hwpe_req", hwpe_req_o, 1'b0);
        chk("rs_gnt", core_gnt_o, 4'b0000);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
